unsat_clause_selector: RTL and testbench
========================================

Name: unsat_clause_selector

Overview:
- Sequential successor to the combinational unsatisfied-clause priority tree in the MCMC constraint solver.
- Snapshots the per-clause satisfied flags from the clause checkers and counts the unsatisfied clauses.
- Selects one unsatisfied clause index using a runtime-selectable policy: lowest index, uniform random, or round-robin.
- Drives the index to the WalkSAT/MCMC move stage over a valid/ack handshake.

Parameters:
- MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX, 2, log2 of clause count; N = 2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX.
- RANDOM_WIDTH, 8, width of the random word used in random mode.

Ports:
- in_clk  input  1  clock; all state updates on the rising edge.
- in_reset  input  1  asynchronous, active-high reset.
- in_start  input  1  request a selection; sampled only in IDLE.
- in_mode  input  2  selection policy, latched at start: 0 lowest index, 1 random, 2 round-robin, 3 treated as 0.
- in_clause_satisfied  input  N  bit i = 1 means clause i is satisfied; latched at start.
- in_random  input  RANDOM_WIDTH  random word, latched at start.
- in_ack  input  1  consumer accepts the result; meaningful only while out_valid = 1.
- out_busy  output  1  high in COUNT and SCAN.
- out_valid  output  1  high in DONE; result outputs stable while high.
- out_all_satisfied  output  1  snapshot had no unsatisfied clause.
- out_clause_index  output  MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX  selected unsatisfied clause.
- out_unsat_count  output  MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX+1  number of unsatisfied clauses in the snapshot (0..N).

Behaviour:
- Reset (asynchronous, any state, including mid-scan):
  - State goes to IDLE.
  - All outputs go to 0.
  - Internal snapshot, remaining counter and scan pointer go to 0.
  - Round-robin last-index register goes to N-1, so the first round-robin search starts at clause 0.
- FSM states: IDLE, COUNT, SCAN, DONE.
- IDLE:
  - At an edge with in_start = 1, latch in_clause_satisfied, in_mode and in_random, then go to COUNT.
  - Clear out_all_satisfied.
- COUNT (exactly one cycle):
  - c = popcount(~snapshot), registered into out_unsat_count.
  - If c = 0: set out_all_satisfied = 1, out_clause_index = 0, go to DONE.
  - Otherwise set the target rank t and the start pointer p, then go to SCAN:
    - Mode 0 (and 3): t = 0, p = 0.
    - Mode 1: t = (rand * c) >> RANDOM_WIDTH, computed at full width (RANDOM_WIDTH + MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX + 1 bits), so 0 <= t < c. No divider.
    - Mode 2: t = 0, p = (last + 1) mod N.
- SCAN (one clause per cycle, examines snapshot[p]):
  - If clause p is unsatisfied and remaining = 0: latch out_clause_index = p; in mode 2 also update last = p; go to DONE.
  - If clause p is unsatisfied and remaining > 0: decrement remaining.
  - p increments mod N every cycle (wrap-around from N-1 to 0 is required).
  - Termination is guaranteed within N scan cycles because t < c.
- DONE:
  - out_valid = 1.
  - At an edge with in_ack = 1, go to IDLE (out_valid falls after that edge).
  - Without in_ack, hold indefinitely.
- Latency:
  - Start sampled at edge E0; SCAN entered after E1.
  - If the selected clause is m pointer steps from p, DONE is entered at edge E(2+m); out_valid is high the cycle after.
  - All-satisfied case: DONE at E1.
- Simultaneous events:
  - in_start while not IDLE is ignored; no queuing.
  - in_start together with in_ack in DONE: the ack is honoured and the start is ignored; a new start is needed in IDLE.
  - Input changes after the start edge do not affect the result.
- out_unsat_count and out_clause_index hold their values after ack until the next COUNT/SCAN update.

Test Plan:
1. N=4, mode 1, satisfied=4'b0101 (clauses 1 and 3 unsatisfied), random=8'h80 -> count=2, t=1, index=3, out_valid first high after E(2+3); repeat with random=8'h7F -> t=0, index=1.
2. Mode 0, satisfied=4'b1011 -> count=1, index=2, out_valid after E4, out_all_satisfied=0.
3. satisfied=4'b1111, any mode -> out_all_satisfied=1, out_unsat_count=0, out_clause_index=0, out_valid after E1.
4. Mode 2, satisfied=4'b0000, five start/ack runs -> indices 0,1,2,3,0 (wrap); then satisfied=4'b1110 -> index 0 with a pointer wrap inside the scan.
5. Hold in_ack=0 for 10 cycles in DONE -> out_valid and index stable, in_start pulses ignored; ack -> IDLE next cycle.
6. Assert in_reset mid-SCAN (mode 1, satisfied=4'b0000, random=8'hFF) -> all outputs 0 immediately; a following mode 2 run selects index 0.

Source files
------------

// File: rtl/unsat_clause_selector.sv
// Sequential unsatisfied-clause selector: snapshots clause flags, counts the unsatisfied
// ones, then scans for one chosen by lowest-index, uniform-random or round-robin policy.
module unsat_clause_selector #(
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 2,
    parameter int RANDOM_WIDTH                       = 8
) (
    input  logic                                          in_clk,
    input  logic                                          in_reset,
    input  logic                                          in_start,
    input  logic [1:0]                                    in_mode,
    input  logic [(2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] in_clause_satisfied,
    input  logic [RANDOM_WIDTH-1:0]                       in_random,
    input  logic                                          in_ack,
    output logic                                          out_busy,
    output logic                                          out_valid,
    output logic                                          out_all_satisfied,
    output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
    output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0]   out_unsat_count
);
    localparam int IW = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
    localparam int N  = 2 ** IW;
    localparam int CW = IW + 1;
    localparam int PW = RANDOM_WIDTH + CW;

    typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_SCAN, ST_DONE} state_t;

    state_t                  state_q, state_d;
    logic [N-1:0]            snap_q, snap_d;
    logic [1:0]              mode_q, mode_d;
    logic [RANDOM_WIDTH-1:0] rand_q, rand_d;
    logic [CW-1:0]           remaining_q, remaining_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [IW-1:0]           last_q, last_d;
    logic [IW-1:0]           index_q, index_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    all_sat_q, all_sat_d;

    logic [CW-1:0]           unsat_cnt;
    logic [PW-1:0]           product;
    logic [CW-1:0]           rand_target;

    always_comb begin
        unsat_cnt = '0;
        for (int i = 0; i < N; i++) begin
            unsat_cnt = unsat_cnt + {{IW{1'b0}}, ~snap_q[i]};
        end
    end

    // Scaled multiply maps the random word onto [0, count) without a divider.
    assign product     = PW'(rand_q) * PW'(unsat_cnt);
    assign rand_target = CW'(product >> RANDOM_WIDTH);

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        mode_d      = mode_q;
        rand_d      = rand_q;
        remaining_d = remaining_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        index_d     = index_q;
        count_d     = count_q;
        all_sat_d   = all_sat_q;
        case (state_q)
            ST_IDLE: begin
                all_sat_d = 1'b0;
                if (in_start) begin
                    snap_d  = in_clause_satisfied;
                    mode_d  = in_mode;
                    rand_d  = in_random;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                count_d = unsat_cnt;
                if (unsat_cnt == '0) begin
                    all_sat_d = 1'b1;
                    index_d   = '0;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_SCAN;
                    case (mode_q)
                        2'd1: begin
                            remaining_d = rand_target;
                            ptr_d       = '0;
                        end
                        2'd2: begin
                            remaining_d = '0;
                            ptr_d       = last_q + IW'(1);
                        end
                        default: begin
                            remaining_d = '0;
                            ptr_d       = '0;
                        end
                    endcase
                end
            end
            ST_SCAN: begin
                ptr_d = ptr_q + IW'(1);
                if (!snap_q[ptr_q]) begin
                    if (remaining_q == '0) begin
                        index_d = ptr_q;
                        if (mode_q == 2'd2) begin
                            last_d = ptr_q;
                        end
                        state_d = ST_DONE;
                    end else begin
                        remaining_d = remaining_q - CW'(1);
                    end
                end
            end
            ST_DONE: begin
                if (in_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q     <= ST_IDLE;
            snap_q      <= '0;
            mode_q      <= '0;
            rand_q      <= '0;
            remaining_q <= '0;
            ptr_q       <= '0;
            last_q      <= IW'(N - 1);
            index_q     <= '0;
            count_q     <= '0;
            all_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            mode_q      <= mode_d;
            rand_q      <= rand_d;
            remaining_q <= remaining_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            index_q     <= index_d;
            count_q     <= count_d;
            all_sat_q   <= all_sat_d;
        end
    end

    assign out_busy          = (state_q == ST_COUNT) || (state_q == ST_SCAN);
    assign out_valid         = (state_q == ST_DONE);
    assign out_all_satisfied = all_sat_q;
    assign out_clause_index  = index_q;
    assign out_unsat_count   = count_q;

endmodule

// File: tb/tb_unsat_clause_selector.sv
// Directed table-driven bench for unsat_clause_selector (N = 4, 8-bit random word),
// plus hand sequences for ack hold-off and mid-scan reset.
module tb_unsat_clause_selector;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_start;
    logic [1:0] in_mode;
    logic [3:0] in_sat;
    logic [7:0] in_random;
    logic       in_ack;
    logic       out_busy;
    logic       out_valid;
    logic       out_all_satisfied;
    logic [1:0] out_clause_index;
    logic [2:0] out_unsat_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] sat;
        logic [7:0] rnd;
        int         cnt;
        int         idx;
        int         all;
        int         lat;
    } vec_t;

    vec_t vecs[17];

    unsat_clause_selector #(
        .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(2),
        .RANDOM_WIDTH(8)
    ) dut (
        .in_clk             (clk),
        .in_reset           (rst),
        .in_start           (in_start),
        .in_mode            (in_mode),
        .in_clause_satisfied(in_sat),
        .in_random          (in_random),
        .in_ack             (in_ack),
        .out_busy           (out_busy),
        .out_valid          (out_valid),
        .out_all_satisfied  (out_all_satisfied),
        .out_clause_index   (out_clause_index),
        .out_unsat_count    (out_unsat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Start a selection and wait for out_valid; returns edges from start edge to DONE.
    task automatic start_and_wait(input vec_t v, input string name, output int k);
        bit got;
        @(negedge clk);
        in_mode   = v.mode;
        in_sat    = v.sat;
        in_random = v.rnd;
        in_start  = 1'b1;
        @(posedge clk);
        #1;
        in_start  = 1'b0;
        in_sat    = ~v.sat;
        in_random = ~v.rnd;
        in_mode   = v.mode ^ 2'b01;
        k   = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        check({name, " latency"}, k, v.lat);
    endtask

    task automatic do_ack(input string name);
        @(negedge clk);
        in_ack = 1'b1;
        @(posedge clk);
        #1;
        in_ack = 1'b0;
        @(negedge clk);
        check({name, " valid after ack"}, int'(out_valid), 0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int k;
        start_and_wait(v, name, k);
        $display("%s: mode=%0d sat=%b rnd=%02h -> cnt=%0d idx=%0d all=%0d lat=%0d", name,
                 v.mode, v.sat, v.rnd, out_unsat_count, out_clause_index, out_all_satisfied, k);
        check({name, " count"}, int'(out_unsat_count), v.cnt);
        check({name, " index"}, int'(out_clause_index), v.idx);
        check({name, " all_sat"}, int'(out_all_satisfied), v.all);
        check({name, " busy in done"}, int'(out_busy), 0);
        do_ack(name);
    endtask

    initial begin
        int k;
        vecs[0]  = '{2'd1, 4'b0101, 8'h80, 2, 3, 0, 5};
        vecs[1]  = '{2'd1, 4'b0101, 8'h7F, 2, 1, 0, 3};
        vecs[2]  = '{2'd0, 4'b1011, 8'h00, 1, 2, 0, 4};
        vecs[3]  = '{2'd3, 4'b1011, 8'hC3, 1, 2, 0, 4};
        vecs[4]  = '{2'd1, 4'b1111, 8'h55, 0, 0, 1, 1};
        vecs[5]  = '{2'd0, 4'b0000, 8'h00, 4, 0, 0, 2};
        vecs[6]  = '{2'd1, 4'b0000, 8'hFF, 4, 3, 0, 5};
        vecs[7]  = '{2'd1, 4'b0110, 8'hFF, 2, 3, 0, 5};
        vecs[8]  = '{2'd2, 4'b0000, 8'h00, 4, 0, 0, 2};
        vecs[9]  = '{2'd2, 4'b0000, 8'h00, 4, 1, 0, 2};
        vecs[10] = '{2'd2, 4'b0000, 8'h00, 4, 2, 0, 2};
        vecs[11] = '{2'd2, 4'b0000, 8'h00, 4, 3, 0, 2};
        vecs[12] = '{2'd2, 4'b0000, 8'h00, 4, 0, 0, 2};
        vecs[13] = '{2'd2, 4'b1110, 8'h00, 1, 0, 0, 5};
        vecs[14] = '{2'd2, 4'b1111, 8'h00, 0, 0, 1, 1};
        vecs[15] = '{2'd2, 4'b0000, 8'h00, 4, 1, 0, 2};
        vecs[16] = '{2'd0, 4'b0111, 8'h9A, 1, 3, 0, 5};

        rst       = 1'b1;
        in_start  = 1'b0;
        in_mode   = 2'd0;
        in_sat    = 4'hF;
        in_random = 8'h00;
        in_ack    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", int'(out_busy), 0);
        check("reset valid", int'(out_valid), 0);
        check("reset count", int'(out_unsat_count), 0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Hold DONE without ack; start pulses must be ignored.
        begin
            vec_t h;
            h = '{2'd0, 4'b1011, 8'h00, 1, 2, 0, 4};
            start_and_wait(h, "hold", k);
            for (int i = 0; i < 10; i++) begin
                in_start = i[0];
                in_sat   = 4'b0000;
                in_mode  = 2'd2;
                @(posedge clk);
                @(negedge clk);
                check($sformatf("hold%0d valid", i), int'(out_valid), 1);
                check($sformatf("hold%0d index", i), int'(out_clause_index), 2);
                check($sformatf("hold%0d busy", i), int'(out_busy), 0);
            end
            $display("hold: valid stayed with idx=%0d", out_clause_index);
            in_ack   = 1'b1;
            in_start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_ack   = 1'b0;
            in_start = 1'b0;
            check("ack+start valid", int'(out_valid), 0);
            check("ack+start busy", int'(out_busy), 0);
            @(posedge clk);
            @(negedge clk);
            check("start ignored busy", int'(out_busy), 0);
            check("kept count", int'(out_unsat_count), 1);
        end

        // Asynchronous reset in the middle of a scan.
        @(negedge clk);
        in_mode   = 2'd1;
        in_sat    = 4'b0000;
        in_random = 8'hFF;
        in_start  = 1'b1;
        @(posedge clk);
        #1;
        in_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midscan busy", int'(out_busy), 1);
        check("midscan count", int'(out_unsat_count), 4);
        #2;
        rst = 1'b1;
        #1;
        check("async rst busy", int'(out_busy), 0);
        check("async rst valid", int'(out_valid), 0);
        check("async rst count", int'(out_unsat_count), 0);
        check("async rst index", int'(out_clause_index), 0);
        check("async rst all_sat", int'(out_all_satisfied), 0);
        $display("reset mid-scan: busy=%0d cnt=%0d", out_busy, out_unsat_count);
        @(negedge clk);
        rst = 1'b0;
        begin
            vec_t r;
            r = '{2'd2, 4'b0000, 8'h00, 4, 0, 0, 2};
            run_vec(r, "post-reset rr");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
